l2_read_arbiter: RTL and testbench

//  Shares one single-port L2 SRAM read port between the DLA_CORE weight and activation read

---
 rtl/l2_read_arbiter.sv | 86 ++++++++
 tb/tb_l2_read_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_read_arbiter.sv
// l2_read_arbiter: round-robin share of one L2 SRAM read port between weight and activation channels.
// Optional L2_ARB_PERF_EN adds saturating grant/conflict counters with synchronous perf_clr.
module l2_read_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              arb_en,
  input  logic [ADDR_W-1:0] wei_base,
  input  logic [ADDR_W-1:0] act_base,
  input  logic              wei_buf_read_ready,
  input  logic [ADDR_W-1:0] wei_buf_read_addr,
  output logic              wei_buf_read_valid,
  output logic [DATA_W-1:0] wei_buf_read_data,
  input  logic              act_buf_read_ready,
  input  logic [ADDR_W-1:0] act_buf_read_addr,
  output logic              act_buf_read_valid,
  output logic [DATA_W-1:0] act_buf_read_data,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef L2_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_wei_grants,
  output logic [31:0]       perf_act_grants,
  output logic [31:0]       perf_conflicts
`endif
);
  logic              pend_w, pend_a, last_a;
  logic              elig_w, elig_a, gnt_w, gnt_a;
  logic [RD_LAT-1:0] pv, pa;
  // rst_n gates eligibility so no grant leaks out while reset is held
  always_comb begin
    elig_w    = rst_n & arb_en & wei_buf_read_ready & ~pend_w;
    elig_a    = rst_n & arb_en & act_buf_read_ready & ~pend_a;
    gnt_w     = elig_w & (~elig_a | last_a);
    gnt_a     = elig_a & ~gnt_w;
    sram_en   = gnt_w | gnt_a;
    sram_addr = gnt_w ? wei_base + wei_buf_read_addr : gnt_a ? act_base + act_buf_read_addr : '0;
  end
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) begin
      pv                 <= '0;
      pa                 <= '0;
      last_a             <= 1'b1;
      pend_w             <= 1'b0;
      pend_a             <= 1'b0;
      wei_buf_read_valid <= 1'b0;
      act_buf_read_valid <= 1'b0;
      wei_buf_read_data  <= '0;
      act_buf_read_data  <= '0;
    end else begin
      pv[0] <= sram_en;
      pa[0] <= gnt_a;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      last_a             <= sram_en ? gnt_a : last_a;
      pend_w             <= gnt_w | (pend_w & ~wei_buf_read_valid);
      pend_a             <= gnt_a | (pend_a & ~act_buf_read_valid);
      wei_buf_read_valid <= pv[RD_LAT-1] & ~pa[RD_LAT-1];
      act_buf_read_valid <= pv[RD_LAT-1] & pa[RD_LAT-1];
      wei_buf_read_data  <= (pv[RD_LAT-1] & ~pa[RD_LAT-1]) ? sram_rdata : wei_buf_read_data;
      act_buf_read_data  <= (pv[RD_LAT-1] & pa[RD_LAT-1]) ? sram_rdata : act_buf_read_data;
    end
`ifdef L2_ARB_PERF_EN
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) begin
      perf_wei_grants <= '0;
      perf_act_grants <= '0;
      perf_conflicts  <= '0;
    end else if (perf_clr) begin
      perf_wei_grants <= '0;
      perf_act_grants <= '0;
      perf_conflicts  <= '0;
    end else begin
      perf_wei_grants <= perf_wei_grants + {31'd0, gnt_w & ~&perf_wei_grants};
      perf_act_grants <= perf_act_grants + {31'd0, gnt_a & ~&perf_act_grants};
      perf_conflicts  <= perf_conflicts + {31'd0, elig_w & elig_a & ~&perf_conflicts};
    end
`endif
endmodule

// File: tb/tb_l2_read_arbiter.sv
// tb_l2_read_arbiter: directed scenario bench for l2_read_arbiter with a 1-cycle SRAM model.
module tb_l2_read_arbiter;
  logic        core_clk = 0, rst_n = 0, arb_en = 0;
  logic [11:0] wei_base = 0, act_base = 0, wei_addr = 0, act_addr = 0, sram_addr;
  logic        wei_ready = 0, act_ready = 0, wei_valid, act_valid, sram_en;
  logic [63:0] wei_data, act_data, sram_rdata = 0;
  int          n_chk = 0, n_fail = 0;
`ifdef L2_ARB_PERF_EN
  logic        perf_clr = 0;
  logic [31:0] perf_wei_grants, perf_act_grants, perf_conflicts;
`endif

  l2_read_arbiter dut (
    .core_clk(core_clk), .rst_n(rst_n), .arb_en(arb_en),
    .wei_base(wei_base), .act_base(act_base),
    .wei_buf_read_ready(wei_ready), .wei_buf_read_addr(wei_addr),
    .wei_buf_read_valid(wei_valid), .wei_buf_read_data(wei_data),
    .act_buf_read_ready(act_ready), .act_buf_read_addr(act_addr),
    .act_buf_read_valid(act_valid), .act_buf_read_data(act_data),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata)
`ifdef L2_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_wei_grants(perf_wei_grants),
    .perf_act_grants(perf_act_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 core_clk = ~core_clk;

  function automatic logic [63:0] mem(input logic [11:0] a);
    return {20'hABCDE, a, 20'h12345, a};
  endfunction

  always @(posedge core_clk) sram_rdata <= sram_en ? mem(sram_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic tick;
    @(posedge core_clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [11:0] wa, wb, input logic ar, input logic [11:0] aa, ab);
    wei_ready = wr; wei_addr = wa; wei_base = wb;
    act_ready = ar; act_addr = aa; act_base = ab;
  endtask

  task automatic do_reset;
    rst_n = 0; arb_en = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick; tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 0; arb_en = 1;
    drive(1, 5, 12'h100, 1, 2, 12'h200);
    tick; #1;
    n_chk += 5;
    if (sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b exp 0", sram_en); end
    if (wei_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wv got %b exp 0", wei_valid); end
    if (act_valid !== 1'b0) begin n_fail++; $display("FAIL reset_av got %b exp 0", act_valid); end
    if (wei_data !== 64'd0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", wei_data); end
    if (act_data !== 64'd0) begin n_fail++; $display("FAIL reset_adata got %h exp 0", act_data); end
  endtask

  task automatic test_single;
    logic        ee [7] = '{1, 0, 0, 1, 0, 0, 0};
    logic [11:0] ea [7] = '{12'h105, 0, 0, 12'h105, 0, 0, 0};
    logic        ew [7] = '{0, 0, 1, 0, 0, 1, 0};
    do_reset;
    drive(1, 5, 12'h100, 0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      if (c == 4) wei_ready = 0;
      #1;
      n_chk += 4;
      if (sram_en !== ee[c]) begin n_fail++; $display("FAIL single_en c%0d got %b exp %b", c, sram_en, ee[c]); end
      if (sram_addr !== ea[c]) begin n_fail++; $display("FAIL single_addr c%0d got %h exp %h", c, sram_addr, ea[c]); end
      if (wei_valid !== ew[c]) begin n_fail++; $display("FAIL single_wv c%0d got %b exp %b", c, wei_valid, ew[c]); end
      if (act_valid !== 1'b0) begin n_fail++; $display("FAIL single_av c%0d got %b exp 0", c, act_valid); end
      if (c >= 2) begin
        n_chk++;
        if (wei_data !== mem(12'h105)) begin n_fail++; $display("FAIL single_wdata c%0d got %h exp %h", c, wei_data, mem(12'h105)); end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic        ee [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic [11:0] ea [7] = '{12'h105, 12'h202, 0, 12'h105, 12'h202, 0, 12'h105};
    logic        ew [7] = '{0, 0, 1, 0, 0, 1, 0};
    logic        ev [7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset;
    drive(1, 5, 12'h100, 1, 2, 12'h200);
    for (int c = 0; c < 7; c++) begin
      #1;
      n_chk += 4;
      if (sram_en !== ee[c]) begin n_fail++; $display("FAIL b2b_en c%0d got %b exp %b", c, sram_en, ee[c]); end
      if (sram_addr !== ea[c]) begin n_fail++; $display("FAIL b2b_addr c%0d got %h exp %h", c, sram_addr, ea[c]); end
      if (wei_valid !== ew[c]) begin n_fail++; $display("FAIL b2b_wv c%0d got %b exp %b", c, wei_valid, ew[c]); end
      if (act_valid !== ev[c]) begin n_fail++; $display("FAIL b2b_av c%0d got %b exp %b", c, act_valid, ev[c]); end
      if (ew[c]) begin
        n_chk++;
        if (wei_data !== mem(12'h105)) begin n_fail++; $display("FAIL b2b_wdata c%0d got %h exp %h", c, wei_data, mem(12'h105)); end
      end
      if (ev[c]) begin
        n_chk++;
        if (act_data !== mem(12'h202)) begin n_fail++; $display("FAIL b2b_adata c%0d got %h exp %h", c, act_data, mem(12'h202)); end
      end
      tick;
    end
    drive(0, 0, 0, 0, 0, 0);
    tick; tick; tick;
  endtask

  task automatic test_wrap;
    logic        ee [4] = '{1, 0, 0, 1};
    logic [11:0] ea [4] = '{12'h001, 0, 0, 12'h001};
    logic        ev [4] = '{0, 0, 1, 0};
    do_reset;
    drive(0, 0, 0, 1, 2, 12'hFFF);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk += 3;
      if (sram_en !== ee[c]) begin n_fail++; $display("FAIL wrap_en c%0d got %b exp %b", c, sram_en, ee[c]); end
      if (sram_addr !== ea[c]) begin n_fail++; $display("FAIL wrap_addr c%0d got %h exp %h", c, sram_addr, ea[c]); end
      if (act_valid !== ev[c]) begin n_fail++; $display("FAIL wrap_av c%0d got %b exp %b", c, act_valid, ev[c]); end
      if (ev[c]) begin
        n_chk++;
        if (act_data !== mem(12'h001)) begin n_fail++; $display("FAIL wrap_adata c%0d got %h exp %h", c, act_data, mem(12'h001)); end
      end
      tick;
    end
  endtask

  task automatic test_arb_en;
    logic        en [7] = '{1, 0, 0, 0, 1, 1, 1};
    logic        ee [7] = '{1, 0, 0, 0, 1, 1, 0};
    logic [11:0] ea [7] = '{12'h105, 0, 0, 0, 12'h202, 12'h105, 0};
    logic        ew [7] = '{0, 0, 1, 0, 0, 0, 0};
    logic        ev [7] = '{0, 0, 0, 0, 0, 0, 1};
    do_reset;
    drive(1, 5, 12'h100, 1, 2, 12'h200);
    for (int c = 0; c < 7; c++) begin
      arb_en = en[c];
      #1;
      n_chk += 4;
      if (sram_en !== ee[c]) begin n_fail++; $display("FAIL arben_en c%0d got %b exp %b", c, sram_en, ee[c]); end
      if (sram_addr !== ea[c]) begin n_fail++; $display("FAIL arben_addr c%0d got %h exp %h", c, sram_addr, ea[c]); end
      if (wei_valid !== ew[c]) begin n_fail++; $display("FAIL arben_wv c%0d got %b exp %b", c, wei_valid, ew[c]); end
      if (act_valid !== ev[c]) begin n_fail++; $display("FAIL arben_av c%0d got %b exp %b", c, act_valid, ev[c]); end
      tick;
    end
  endtask

  task automatic test_mid_reset;
    logic        rs [5] = '{1, 0, 1, 1, 1};
    logic        ar [5] = '{0, 1, 1, 1, 1};
    logic        ee [5] = '{1, 0, 1, 1, 0};
    logic [11:0] ea [5] = '{12'h105, 0, 12'h105, 12'h202, 0};
    logic        ew [5] = '{0, 0, 0, 0, 1};
    do_reset;
    drive(1, 5, 12'h100, 0, 2, 12'h200);
    for (int c = 0; c < 5; c++) begin
      rst_n = rs[c];
      act_ready = ar[c];
      #1;
      n_chk += 4;
      if (sram_en !== ee[c]) begin n_fail++; $display("FAIL mrst_en c%0d got %b exp %b", c, sram_en, ee[c]); end
      if (sram_addr !== ea[c]) begin n_fail++; $display("FAIL mrst_addr c%0d got %h exp %h", c, sram_addr, ea[c]); end
      if (wei_valid !== ew[c]) begin n_fail++; $display("FAIL mrst_wv c%0d got %b exp %b", c, wei_valid, ew[c]); end
      if (act_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_av c%0d got %b exp 0", c, act_valid); end
      if (c == 3) begin
        n_chk++;
        if (wei_data !== 64'd0) begin n_fail++; $display("FAIL mrst_wdata_discard got %h exp 0", wei_data); end
      end
      tick;
    end
  endtask

`ifdef L2_ARB_PERF_EN
  task automatic test_perf;
    do_reset;
    drive(1, 5, 12'h100, 1, 2, 12'h200);
    for (int c = 0; c < 10; c++) tick;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_chk += 3;
    if (perf_wei_grants !== 32'd4) begin n_fail++; $display("FAIL perf_wei got %0d exp 4", perf_wei_grants); end
    if (perf_act_grants !== 32'd3) begin n_fail++; $display("FAIL perf_act got %0d exp 3", perf_act_grants); end
    if (perf_conflicts !== 32'd1) begin n_fail++; $display("FAIL perf_conf got %0d exp 1", perf_conflicts); end
    perf_clr = 1;
    drive(1, 5, 12'h100, 1, 2, 12'h200);
    tick;
    perf_clr = 0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_chk += 3;
    if (perf_wei_grants !== 32'd0) begin n_fail++; $display("FAIL perf_clr_wei got %0d exp 0", perf_wei_grants); end
    if (perf_act_grants !== 32'd0) begin n_fail++; $display("FAIL perf_clr_act got %0d exp 0", perf_act_grants); end
    if (perf_conflicts !== 32'd0) begin n_fail++; $display("FAIL perf_clr_conf got %0d exp 0", perf_conflicts); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_wrap;
    test_arb_en;
    test_mid_reset;
`ifdef L2_ARB_PERF_EN
    test_perf;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
